// File: rtl/alu_control.sv
// rtl/alu_control.sv - opcode-driven 16-bit register/ALU execution core (optional illegal_op via CONTROL_ILLEGAL_OP_EN)
module alu_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] opcode,
    input  logic [15:0] Mem_Dat_X,
    input  logic [15:0] Mem_Dat_Y,
    output logic [15:0] Aout,
    output logic [15:0] Bout,
    output logic [15:0] Cout
`ifdef CONTROL_ILLEGAL_OP_EN
    ,
    output logic        illegal_op
`endif
);

    localparam logic [3:0] F_ADD    = 4'h0;
    localparam logic [3:0] F_SHL    = 4'h3;
    localparam logic [3:0] F_ANDLSB = 4'h5;
    localparam logic [3:0] F_NEG    = 4'h8;
    localparam logic [3:0] F_WRA    = 4'h9;
    localparam logic [3:0] F_SHR    = 4'hA;
    localparam logic [3:0] F_WRB    = 4'hB;
    localparam logic [3:0] F_WRC    = 4'hC;

    logic [15:0] a, b, c;
    logic [15:0] ao, bo, co;

    logic [3:0]  func;
    logic [1:0]  src_sel;
    logic [15:0] wb_data;
    logic        and_bit;
    logic        func_legal;

    assign func    = opcode[3:0];
    assign src_sel = opcode[11:10];

    // Memory loads take Y only for C; result-register sources prefer Co, then Bo, then Ao.
    always_comb begin
        wb_data = ao;
        if (src_sel == 2'b00) begin
            wb_data = (func == F_WRC) ? Mem_Dat_Y : Mem_Dat_X;
        end else if (opcode[7]) begin
            wb_data = co;
        end else if (opcode[6]) begin
            wb_data = bo;
        end
    end

    assign and_bit = opcode[8] ? co[0] : c[0];

    always_comb begin
        func_legal = 1'b0;
        case (func)
            F_ADD, F_SHL, F_ANDLSB, F_NEG,
            F_WRA, F_SHR, F_WRB, F_WRC: func_legal = 1'b1;
            default:                    func_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a  <= 16'h0000;
            b  <= 16'h0000;
            c  <= 16'h0000;
            ao <= 16'h0000;
            bo <= 16'h0000;
            co <= 16'h0000;
        end else begin
            case (func)
                F_ADD:    ao <= a + c;
                F_SHL:    bo <= {b[14:0], 1'b0};
                F_ANDLSB: ao <= b & {16{and_bit}};
                F_NEG:    bo <= ~b + 16'h0001;
                F_SHR:    co <= {c[15], c[15:1]};
                F_WRA:    a  <= wb_data;
                F_WRB:    b  <= wb_data;
                F_WRC:    c  <= wb_data;
                default:  ;
            endcase
        end
    end

`ifdef CONTROL_ILLEGAL_OP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= ~func_legal;
        end
    end
`else
    logic unused_legal;
    assign unused_legal = func_legal;
`endif

    assign Aout = ao;
    assign Bout = bo;
    assign Cout = co;

endmodule

// File: tb/tb_alu_control.sv
// tb/tb_alu_control.sv - scoreboard bench for alu_control with a behavioural register model
module tb_alu_control;

    logic        clk;
    logic        rst;
    logic [11:0] opcode;
    logic [15:0] mem_x;
    logic [15:0] mem_y;
    logic [15:0] aout, bout, cout;
`ifdef CONTROL_ILLEGAL_OP_EN
    logic        illegal_op;
`endif

    alu_control dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .Mem_Dat_X (mem_x),
        .Mem_Dat_Y (mem_y),
        .Aout      (aout),
        .Bout      (bout),
        .Cout      (cout)
`ifdef CONTROL_ILLEGAL_OP_EN
        ,
        .illegal_op(illegal_op)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ea, eb, ec;
        logic        eill;
        logic [2:0]  dm;
        logic [15:0] dv;
        int          id;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   step_id = 0;
    bit   done = 0;

    // Model state: 0=A 1=B 2=C 3=Ao 4=Bo 5=Co, each kept as 0..65535
    int m[6];

    task automatic chk(input string name, input int id, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %04h expected %04h", name, id, act, exp);
        end
    endtask

    task automatic step(input logic [11:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic r, input logic [2:0] dm, input logic [15:0] dv);
        exp_t e;
        int   f, src, bitv;
        @(negedge clk);
        opcode = o;
        mem_x  = x;
        mem_y  = y;
        rst    = r;
        f      = int'(o[3:0]);
        e.eill = 1'b0;
        if (r) begin
            for (int i = 0; i < 6; i++) m[i] = 0;
        end else begin
            if (o[11:10] == 2'b00) src = (f == 12) ? int'(y) : int'(x);
            else if (o[7])         src = m[5];
            else if (o[6])         src = m[4];
            else                   src = m[3];
            case (f)
                0:  m[3] = (m[0] + m[2]) % 65536;
                3:  m[4] = (m[1] * 2) % 65536;
                5:  begin
                        bitv = o[8] ? (m[5] % 2) : (m[2] % 2);
                        m[3] = (bitv == 1) ? m[1] : 0;
                    end
                8:  m[4] = (65536 - m[1]) % 65536;
                10: m[5] = m[2] / 2 + ((m[2] >= 32768) ? 32768 : 0);
                9:  m[0] = src;
                11: m[1] = src;
                12: m[2] = src;
                default: e.eill = 1'b1;
            endcase
        end
        e.ea = m[3];
        e.eb = m[4];
        e.ec = m[5];
        e.dm = dm;
        e.dv = dv;
        e.id = step_id;
        step_id++;
        q.push_back(e);
    endtask

    task automatic run_op(input logic [11:0] o, input logic [15:0] x, input logic [15:0] y,
                          input logic [2:0] dm, input logic [15:0] dv);
        step(o, x, y, 1'b0, dm, dv);
    endtask

    // Monitor: one expectation per edge, checked 1 time unit after it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("Aout", e.id, int'(aout), e.ea);
                chk("Bout", e.id, int'(bout), e.eb);
                chk("Cout", e.id, int'(cout), e.ec);
                if (e.dm[0]) chk("Aout_directed", e.id, int'(aout), int'(e.dv));
                if (e.dm[1]) chk("Bout_directed", e.id, int'(bout), int'(e.dv));
                if (e.dm[2]) chk("Cout_directed", e.id, int'(cout), int'(e.dv));
`ifdef CONTROL_ILLEGAL_OP_EN
                chk("illegal_op", e.id, int'(illegal_op), int'(e.eill));
`endif
            end
        end
    end

    initial begin
        logic [11:0] ro;
        logic [15:0] rx, ry;
        int          hold_a;
        rst = 1'b1; opcode = 12'h000; mem_x = 16'h0; mem_y = 16'h0;
        for (int i = 0; i < 6; i++) m[i] = 0;

        // Reset state
        step(12'h000, 16'h1234, 16'h5678, 1'b1, 3'b111, 16'h0000);

        // Load / ANDLSB
        run_op(12'h00B, 16'h0005, 16'h0000, 3'b000, 16'h0);
        run_op(12'h00C, 16'h0000, 16'h000E, 3'b000, 16'h0);
        run_op(12'h205, 16'h0000, 16'h0000, 3'b001, 16'h0000);
        run_op(12'h00C, 16'h0000, 16'h000F, 3'b000, 16'h0);
        run_op(12'h205, 16'h0000, 16'h0000, 3'b001, 16'h0005);

        // Shifts
        run_op(12'h00B, 16'h8001, 16'h0000, 3'b000, 16'h0);
        run_op(12'h213, 16'h0000, 16'h0000, 3'b010, 16'h0002);
        run_op(12'h00C, 16'h0000, 16'hFFF1, 3'b000, 16'h0);
        run_op(12'h02A, 16'h0000, 16'h0000, 3'b100, 16'hFFF8);
        run_op(12'h00C, 16'h0000, 16'h0010, 3'b000, 16'h0);
        run_op(12'h02A, 16'h0000, 16'h0000, 3'b100, 16'h0008);

        // NEG including the 0x8000 and 0x0000 fixed points
        run_op(12'h00B, 16'hFFF8, 16'h0000, 3'b000, 16'h0);
        run_op(12'h218, 16'h0000, 16'h0000, 3'b010, 16'h0008);
        run_op(12'h00B, 16'h8000, 16'h0000, 3'b000, 16'h0);
        run_op(12'h218, 16'h0000, 16'h0000, 3'b010, 16'h8000);
        run_op(12'h00B, 16'h0000, 16'h0000, 3'b000, 16'h0);
        run_op(12'h218, 16'h0000, 16'h0000, 3'b010, 16'h0000);

        // Shift-and-add multiply 5 * 14
        run_op(12'h00B, 16'h0005, 16'h0000, 3'b000, 16'h0);
        run_op(12'h00C, 16'h0000, 16'h000E, 3'b000, 16'h0);
        run_op(12'h205, 16'h0000, 16'h0000, 3'b000, 16'h0);
        for (int it = 0; it < 5; it++) begin
            run_op(12'h213, 16'h0, 16'h0, 3'b000, 16'h0);
            run_op(12'h02A, 16'h0, 16'h0, 3'b000, 16'h0);
            run_op(12'h809, 16'h0, 16'h0, 3'b000, 16'h0);
            run_op(12'h84B, 16'h0, 16'h0, 3'b000, 16'h0);
            run_op(12'h385, 16'h0, 16'h0, 3'b000, 16'h0);
            run_op(12'h42C, 16'h0, 16'h0, 3'b000, 16'h0);
            run_op(12'h000, 16'h0, 16'h0, 3'b000, 16'h0);
            run_op(12'h48C, 16'h0, 16'h0, (it == 4) ? 3'b001 : 3'b000, 16'h0046);
        end

        // Idempotent hold, then an unlisted code
        run_op(12'h00B, 16'h0123, 16'h0, 3'b000, 16'h0);
        run_op(12'h809, 16'h0, 16'h0, 3'b000, 16'h0);
        run_op(12'h000, 16'h0, 16'h0, 3'b000, 16'h0);
        hold_a = m[3];
        for (int i = 0; i < 9; i++) run_op(12'h000, 16'($urandom), 16'($urandom), 3'b001, 16'(hold_a));
        run_op(12'h00F, 16'hFFFF, 16'hFFFF, 3'b000, 16'h0);

        // Randomized ops, biased toward listed function codes, with occasional resets
        for (int i = 0; i < 600; i++) begin
            ro = 12'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 7))
                    0: ro[3:0] = 4'h0;
                    1: ro[3:0] = 4'h3;
                    2: ro[3:0] = 4'h5;
                    3: ro[3:0] = 4'h8;
                    4: ro[3:0] = 4'h9;
                    5: ro[3:0] = 4'hA;
                    6: ro[3:0] = 4'hB;
                    default: ro[3:0] = 4'hC;
                endcase
            end
            rx = 16'($urandom);
            ry = 16'($urandom);
            step(ro, rx, ry, ($urandom_range(0, 60) == 0), 3'b000, 16'h0);
        end

        // Mid-sequence reset clears working registers: next ADD gives zero
        step(12'h213, 16'h0, 16'h0, 1'b1, 3'b111, 16'h0000);
        run_op(12'h000, 16'h0, 16'h0, 3'b001, 16'h0000);

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
